// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (hsync/vsync/DE, active x/y,
// line/frame start strobes) driven by per-frame shadowed timing fields.
module video_timing_gen #(
    parameter int   CW     = 16,
    parameter logic HS_POL = 1'b1,
    parameter logic VS_POL = 1'b1
) (
    input  logic          PCLK,
    input  logic          PRST,
    input  logic          i_en,
    input  logic [CW-1:0] i_hsw,
    input  logic [CW-1:0] i_hbp,
    input  logic [CW-1:0] i_hact,
    input  logic [CW-1:0] i_hfp,
    input  logic [CW-1:0] i_vsw,
    input  logic [CW-1:0] i_vbp,
    input  logic [CW-1:0] i_vact,
    input  logic [CW-1:0] i_vfp,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_line_start,
    output logic          o_frame_start,
    output logic          o_busy
);

    typedef enum logic       {IDLE, RUN} top_t;
    typedef enum logic [1:0] {H_SYNC, H_BP, H_ACT, H_FP} h_t;
    typedef enum logic [1:0] {V_SYNC, V_BP, V_ACT, V_FP} v_t;

    // A zero field behaves like one, so the terminal count is clamped at 0.
    function automatic logic [CW-1:0] last_idx(input logic [CW-1:0] f);
        return (f == '0) ? '0 : f - 1'b1;
    endfunction

    function automatic h_t next_h(input h_t h);
        case (h)
            H_SYNC:  return H_BP;
            H_BP:    return H_ACT;
            H_ACT:   return H_FP;
            default: return H_SYNC;
        endcase
    endfunction

    function automatic v_t next_v(input v_t v);
        case (v)
            V_SYNC:  return V_BP;
            V_BP:    return V_ACT;
            V_ACT:   return V_FP;
            default: return V_SYNC;
        endcase
    endfunction

    logic [CW-1:0] sh_hsw, sh_hbp, sh_hact, sh_hfp;
    logic [CW-1:0] sh_vsw, sh_vbp, sh_vact, sh_vfp;

    top_t          top_q, top_d;
    h_t            h_q, h_d;
    v_t            v_q, v_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;

    logic [CW-1:0] h_end, v_end;
    logic          hlast, vlast, line_end, frame_end, load;
    logic          run_d, de_d, ls_d;

    // Phase terminal counts, line/frame end detection and next-state decode.
    always_comb begin
        case (h_q)
            H_SYNC:  h_end = last_idx(sh_hsw);
            H_BP:    h_end = last_idx(sh_hbp);
            H_ACT:   h_end = last_idx(sh_hact);
            default: h_end = last_idx(sh_hfp);
        endcase
        case (v_q)
            V_SYNC:  v_end = last_idx(sh_vsw);
            V_BP:    v_end = last_idx(sh_vbp);
            V_ACT:   v_end = last_idx(sh_vact);
            default: v_end = last_idx(sh_vfp);
        endcase
        hlast     = (hcnt_q == h_end);
        vlast     = (vcnt_q == v_end);
        line_end  = hlast && (h_q == H_FP);
        frame_end = line_end && vlast && (v_q == V_FP);
        load      = i_en && ((top_q == IDLE) || frame_end);

        top_d  = top_q;
        h_d    = h_q;
        v_d    = v_q;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (top_q == IDLE) begin
            h_d    = H_SYNC;
            v_d    = V_SYNC;
            hcnt_d = '0;
            vcnt_d = '0;
            if (i_en) top_d = RUN;
        end else begin
            // Wrapping both FSMs at frame end lands exactly on frame cycle 0.
            if (hlast) begin
                hcnt_d = '0;
                h_d    = next_h(h_q);
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
            if (line_end) begin
                if (vlast) begin
                    vcnt_d = '0;
                    v_d    = next_v(v_q);
                end else begin
                    vcnt_d = vcnt_q + 1'b1;
                end
            end
            if (frame_end && !i_en) top_d = IDLE;
        end

        run_d = (top_d == RUN);
        de_d  = run_d && (h_d == H_ACT) && (v_d == V_ACT);
        ls_d  = run_d && (h_d == H_SYNC) && (hcnt_d == '0);
    end

    // Timing shadow: captured at frame start only, so mid-frame writes wait.
    always_ff @(posedge PCLK) begin
        if (load) begin
            sh_hsw  <= i_hsw;
            sh_hbp  <= i_hbp;
            sh_hact <= i_hact;
            sh_hfp  <= i_hfp;
            sh_vsw  <= i_vsw;
            sh_vbp  <= i_vbp;
            sh_vact <= i_vact;
            sh_vfp  <= i_vfp;
        end
    end

    // FSM state and registered outputs, decoded from the next state.
    always_ff @(posedge PCLK) begin
        if (PRST) begin
            top_q         <= IDLE;
            h_q           <= H_SYNC;
            v_q           <= V_SYNC;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            o_hsync       <= ~HS_POL;
            o_vsync       <= ~VS_POL;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            top_q         <= top_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            o_hsync       <= (run_d && (h_d == H_SYNC)) ? HS_POL : ~HS_POL;
            o_vsync       <= (run_d && (v_d == V_SYNC)) ? VS_POL : ~VS_POL;
            o_de          <= de_d;
            o_x           <= de_d ? hcnt_d : '0;
            o_y           <= (run_d && (v_d == V_ACT)) ? vcnt_d : '0;
            o_line_start  <= ls_d;
            o_frame_start <= ls_d && (v_d == V_SYNC) && (vcnt_d == '0);
            o_busy        <= run_d;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for video_timing_gen. A frame-cycle
// reference model predicts outputs for two instances (active-high and
// active-low syncs); a monitor compares them every cycle.
module tb_video_timing_gen;

    localparam int CW = 16;

    logic          PCLK = 1'b0;
    logic          PRST;
    logic          en;
    logic [CW-1:0] hsw, hbp, hact, hfp, vsw, vbp, vact, vfp;

    logic          a_hs, a_vs, a_de, a_ls, a_fs, a_busy;
    logic [CW-1:0] a_x, a_y;
    logic          b_hs, b_vs, b_de, b_ls, b_fs, b_busy;
    logic [CW-1:0] b_x, b_y;

    typedef struct {
        logic          hs;   // sync asserted (polarity applied per instance)
        logic          vs;
        logic          de;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          ls;
        logic          fs;
        logic          busy;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   chk_n  = 0;
    int   pass_n = 0;

    // Reference model state: idle flag, frame cycle index, latched config.
    bit   m_idle = 1'b1;
    int   m_t    = 0;
    int   ch[4];
    int   cv[4];

    always #5 PCLK = ~PCLK;

    video_timing_gen #(.CW(CW), .HS_POL(1'b1), .VS_POL(1'b1)) dut_a (
        .PCLK(PCLK), .PRST(PRST), .i_en(en),
        .i_hsw(hsw), .i_hbp(hbp), .i_hact(hact), .i_hfp(hfp),
        .i_vsw(vsw), .i_vbp(vbp), .i_vact(vact), .i_vfp(vfp),
        .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de), .o_x(a_x), .o_y(a_y),
        .o_line_start(a_ls), .o_frame_start(a_fs), .o_busy(a_busy)
    );

    video_timing_gen #(.CW(CW), .HS_POL(1'b0), .VS_POL(1'b0)) dut_b (
        .PCLK(PCLK), .PRST(PRST), .i_en(en),
        .i_hsw(hsw), .i_hbp(hbp), .i_hact(hact), .i_hfp(hfp),
        .i_vsw(vsw), .i_vbp(vbp), .i_vact(vact), .i_vfp(vfp),
        .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de), .o_x(b_x), .o_y(b_y),
        .o_line_start(b_ls), .o_frame_start(b_fs), .o_busy(b_busy)
    );

    function automatic int clamp1(input logic [CW-1:0] f);
        return (f == '0) ? 1 : int'(f);
    endfunction

    function automatic int line_len();
        return ch[0] + ch[1] + ch[2] + ch[3];
    endfunction

    function automatic int frame_len();
        return line_len() * (cv[0] + cv[1] + cv[2] + cv[3]);
    endfunction

    task automatic load_cfg();
        ch[0] = clamp1(hsw); ch[1] = clamp1(hbp); ch[2] = clamp1(hact); ch[3] = clamp1(hfp);
        cv[0] = clamp1(vsw); cv[1] = clamp1(vbp); cv[2] = clamp1(vact); cv[3] = clamp1(vfp);
    endtask

    // Expected outputs from the raster position of frame cycle m_t.
    function automatic exp_t expect_now();
        exp_t e;
        int   col, ln, a0, v0;
        bit   hact_in, vact_in;
        e = '{hs: 1'b0, vs: 1'b0, de: 1'b0, x: '0, y: '0, ls: 1'b0, fs: 1'b0, busy: 1'b0};
        if (!m_idle) begin
            col     = m_t % line_len();
            ln      = m_t / line_len();
            a0      = ch[0] + ch[1];
            v0      = cv[0] + cv[1];
            hact_in = (col >= a0) && (col < a0 + ch[2]);
            vact_in = (ln >= v0) && (ln < v0 + cv[2]);
            e.hs    = (col < ch[0]);
            e.vs    = (ln < cv[0]);
            e.de    = hact_in && vact_in;
            e.x     = e.de ? CW'(col - a0) : '0;
            e.y     = vact_in ? CW'(ln - v0) : '0;
            e.ls    = (col == 0);
            e.fs    = (m_t == 0);
            e.busy  = 1'b1;
        end
        return e;
    endfunction

    // Advance the model across the next edge, queue its prediction, clock.
    task automatic step();
        if (PRST) begin
            m_idle = 1'b1;
        end else if (m_idle) begin
            if (en) begin
                load_cfg();
                m_t    = 0;
                m_idle = 1'b0;
            end
        end else begin
            m_t++;
            if (m_t == frame_len()) begin
                if (en) begin
                    load_cfg();
                    m_t = 0;
                end else begin
                    m_idle = 1'b1;
                end
            end
        end
        m_e = expect_now();
        q.push_back(m_e);
        @(posedge PCLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_cfg(input int h0, h1, h2, h3, v0, v1, v2, v3);
        hsw = CW'(h0); hbp = CW'(h1); hact = CW'(h2); hfp = CW'(h3);
        vsw = CW'(v0); vbp = CW'(v1); vact = CW'(v2); vfp = CW'(v3);
    endtask

    // Monitor: one comparison per instance per cycle against the scoreboard.
    always @(negedge PCLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk_n++;
            if (a_hs !== e.hs || a_vs !== e.vs || a_de !== e.de || a_x !== e.x || a_y !== e.y ||
                a_ls !== e.ls || a_fs !== e.fs || a_busy !== e.busy) begin
                $display("FAIL instA t=%0t got hs%b vs%b de%b x%0d y%0d ls%b fs%b bz%b exp hs%b vs%b de%b x%0d y%0d ls%b fs%b bz%b",
                         $time, a_hs, a_vs, a_de, a_x, a_y, a_ls, a_fs, a_busy,
                         e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs, e.busy);
            end else begin
                pass_n++;
            end
            chk_n++;
            if (b_hs !== ~e.hs || b_vs !== ~e.vs || b_de !== e.de || b_x !== e.x || b_y !== e.y ||
                b_ls !== e.ls || b_fs !== e.fs || b_busy !== e.busy) begin
                $display("FAIL instB t=%0t got hs%b vs%b de%b x%0d y%0d ls%b fs%b bz%b exp hs%b vs%b de%b x%0d y%0d ls%b fs%b bz%b",
                         $time, b_hs, b_vs, b_de, b_x, b_y, b_ls, b_fs, b_busy,
                         ~e.hs, ~e.vs, e.de, e.x, e.y, e.ls, e.fs, e.busy);
            end else begin
                pass_n++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lim;
        PRST = 1'b1;
        en   = 1'b0;
        set_cfg(2, 3, 4, 1, 1, 1, 2, 1);
        run(3);
        PRST = 1'b0;
        run(2);

        // Nominal raster, en held high: 10-cycle lines, 50-cycle frames.
        en = 1'b1;
        run(115);

        // hact rewritten around cycle 20 of a frame: applies from next frame.
        lim = 0;
        while (m_t != 19 && lim < 200) begin step(); lim++; end
        hact = 16'd6;
        run(140);

        // en dropped near cycle 7: frame completes, then idle.
        set_cfg(2, 3, 4, 1, 1, 1, 2, 1);
        lim = 0;
        while (m_t != 6 && lim < 200) begin step(); lim++; end
        en = 1'b0;
        run(70);

        // All-zero fields clamp to 1: 4-cycle lines, 16-cycle frames.
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        en = 1'b1;
        run(50);

        // Reset pulse mid-line while o_x == 2, en still high.
        set_cfg(2, 3, 4, 1, 1, 1, 2, 1);
        lim = 0;
        while (!(m_e.de && m_e.x == 2) && lim < 200) begin step(); lim++; end
        PRST = 1'b1;
        step();
        PRST = 1'b0;
        run(60);

        // Randomized configs, en toggling, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3)
                set_cfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 4),
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) en = ~en;
            PRST = ($urandom_range(0, 299) == 0);
            step();
        end
        PRST = 1'b0;
        run(2);

        @(negedge PCLK);
        #1;
        if (q.size() != 0) begin
            chk_n++;
            $display("FAIL drain got %0d pending required 0", q.size());
        end
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule
